// File: rtl/loc_sampler_if.sv
// Port bundle between loc_sampler and its consumer (random source, onegen read port, control).
// rand_in is consumed on any rising edge where rand_valid && rand_ready; the source holds
// rand_in stable while rand_valid is high and not yet accepted.
interface loc_sampler_if #(
  parameter int RAND_W     = 24,
  parameter int M          = 15,
  parameter int LOG_WEIGHT = 7
);
  logic                  start;
  logic [RAND_W-1:0]     rand_in;
  logic                  rand_valid;
  logic                  rand_ready;
  logic                  rd_en;
  logic [LOG_WEIGHT-1:0] rd_addr;
  logic [M-1:0]          location;
  logic                  resample;
  logic [LOG_WEIGHT-1:0] resample_addr;
  logic                  busy;
  logic                  done;
  logic [2:0]            dbg_state;

  modport slave (
    input  start, rand_in, rand_valid, rd_en, rd_addr, resample, resample_addr,
    output rand_ready, location, busy, done, dbg_state
  );

  modport master (
    output start, rand_in, rand_valid, rd_en, rd_addr, resample, resample_addr,
    input  rand_ready, location, busy, done, dbg_state
  );
endinterface

// File: rtl/loc_sampler.sv
// Fixed-weight location sampler: rejection-samples random words below THRESH, reduces them
// mod N with a restoring shift-subtract, and stores WEIGHT locations for onegen to read.
module loc_sampler #(
  parameter int N          = 17669,
  parameter int M          = 15,
  parameter int WEIGHT     = 66,
  parameter int LOG_WEIGHT = $clog2(WEIGHT),
  parameter int RAND_W     = 24,
  parameter int THRESH     = 16767881,
  parameter int KBITS      = 10
) (
  input  logic            clk,
  input  logic            rst,
  loc_sampler_if.slave    bus
);

  localparam int KW = (KBITS > 1) ? $clog2(KBITS) : 1;
  localparam logic [RAND_W-1:0]     N_W      = RAND_W'(N);
  localparam logic [RAND_W-1:0]     THRESH_W = RAND_W'(THRESH);
  localparam logic [LOG_WEIGHT-1:0] LAST_PTR = LOG_WEIGHT'(WEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_REDUCE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_ONE  = 1'b1
  } mode_e;

  state_e                state_q;
  mode_e                 mode_q;
  logic [LOG_WEIGHT-1:0] wr_ptr_q;
  logic [KW-1:0]         k_q;
  logic [RAND_W-1:0]     rem_q;
  logic [RAND_W-1:0]     rem_d;
  logic [RAND_W-1:0]     step_v;
  logic                  rand_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [M-1:0]          location_q;
  logic [M-1:0]          mem [WEIGHT];

  // One restoring step: subtract N<<k when it fits.
  always_comb begin
    step_v = N_W << k_q;
    rem_d  = (rem_q >= step_v) ? (rem_q - step_v) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_FILL;
      wr_ptr_q     <= '0;
      k_q          <= '0;
      rem_q        <= '0;
      rand_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            wr_ptr_q     <= '0;
            mode_q       <= MODE_FILL;
            state_q      <= S_FETCH;
            busy_q       <= 1'b1;
            rand_ready_q <= 1'b1;
          end else if (bus.resample) begin
            wr_ptr_q     <= bus.resample_addr;
            mode_q       <= MODE_ONE;
            state_q      <= S_FETCH;
            busy_q       <= 1'b1;
            rand_ready_q <= 1'b1;
          end
        end
        S_FETCH: begin
          // Rejected words leave the FSM in FETCH with ready still high.
          if (bus.rand_valid && (bus.rand_in < THRESH_W)) begin
            rem_q        <= bus.rand_in;
            k_q          <= KW'(KBITS - 1);
            state_q      <= S_REDUCE;
            rand_ready_q <= 1'b0;
          end
        end
        S_REDUCE: begin
          rem_q <= rem_d;
          if (k_q == '0) state_q <= S_WRITE;
          else           k_q     <= k_q - 1'b1;
        end
        S_WRITE: begin
          if (mode_q == MODE_FILL && wr_ptr_q != LAST_PTR) begin
            wr_ptr_q     <= wr_ptr_q + 1'b1;
            state_q      <= S_FETCH;
            rand_ready_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer RAM is deliberately not reset; out-of-range resample addresses write nothing.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE && wr_ptr_q <= LAST_PTR) begin
      mem[wr_ptr_q] <= rem_q[M-1:0];
    end
  end

  // Read port runs in every state; a same-cycle write to the same entry returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      location_q <= '0;
    end else if (bus.rd_en) begin
      location_q <= mem[bus.rd_addr];
    end
  end

  assign bus.rand_ready = rand_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.location   = location_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_loc_sampler.sv
// Self-checking bench for loc_sampler: directed fills, resample/read corner cases, a vector
// table and randomized traffic against a modulo-arithmetic reference model.
module tb_loc_sampler;
  localparam int N      = 17669;
  localparam int M      = 15;
  localparam int WEIGHT = 66;
  localparam int LW     = 7;
  localparam int RW     = 24;
  localparam int THRESH = 16767881;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_REDUCE = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;

  typedef struct {
    logic [RW-1:0] word;
    logic [M-1:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  loc_sampler_if #(.RAND_W(RW), .M(M), .LOG_WEIGHT(LW)) bus ();

  loc_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_total  = 0;
  int done_cnt = 0;
  logic [M-1:0]  exp_mem [WEIGHT];
  logic [M-1:0]  exp_q[$];
  logic [RW-1:0] word_q[$];
  vec_t          vecs [8];

  always @(negedge clk) if (!rst && bus.done) done_cnt++;

  // Reference model: accepted words map to word mod N.
  function automatic bit accepted(input logic [RW-1:0] w);
    return 32'(w) < 32'(THRESH);
  endfunction

  function automatic logic [M-1:0] ref_loc(input logic [RW-1:0] w);
    logic [31:0] t;
    t = 32'(w);
    return M'(t % 32'(N));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [RW-1:0] w, output bit ok);
    ok = 1'b0;
    bus.rand_in    = w;
    bus.rand_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bus.rand_ready) begin
        tick();
        bus.rand_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      tick();
    end
    bus.rand_valid = 1'b0;
    check("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      if (!bus.busy) return;
      tick();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_loc(input logic [LW-1:0] a, output logic [M-1:0] v);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
    v = bus.location;
  endtask

  task automatic readback_all(input string name);
    logic [M-1:0] v;
    for (int i = 0; i < WEIGHT; i++) begin
      read_loc(LW'(i), v);
      check($sformatf("%s[%0d]", name, i), 32'(v), 32'(exp_mem[i]));
    end
  endtask

  task automatic do_stall();
    bit ok;
    int base;
    for (int c = 0; c < 50 && !bus.rand_ready; c++) tick();
    base = done_cnt;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (bus.dbg_state != ST_FETCH || !bus.rand_ready || bus.busy !== 1'b1) ok = 1'b0;
    end
    check("stall_hold_fetch", 32'(ok), 32'd1);
    check("stall_no_done", done_cnt, base);
  endtask

  // Fill from word_q; expected entries are collected in write order then moved to exp_mem.
  task automatic fill(input int stall_idx);
    bit ok;
    int d0;
    d0 = done_cnt;
    exp_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fill_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < word_q.size(); i++) begin
      if (i == stall_idx) do_stall();
      feed(word_q[i], ok);
      if (!ok) break;
      if (accepted(word_q[i])) exp_q.push_back(ref_loc(word_q[i]));
    end
    wait_idle();
    check("fill_done_once", done_cnt - d0, 32'd1);
    check("fill_busy_low", 32'(bus.busy), 32'd0);
    for (int i = 0; i < WEIGHT && exp_q.size() > 0; i++) exp_mem[i] = exp_q.pop_front();
  endtask

  // Replace one entry; returns cycles from the handshake cycle to the done cycle.
  task automatic resample_one(input logic [LW-1:0] a, input logic [RW-1:0] w,
                              input bit reject_first, input bit poke_start, output int lat);
    bit ok;
    bus.resample      = 1'b1;
    bus.resample_addr = a;
    tick();
    bus.resample = 1'b0;
    if (reject_first) feed(RW'($urandom_range(THRESH, 32'hFFFFFF)), ok);
    feed(w, ok);
    lat = 1;
    while (!bus.done && lat < 60) begin
      bus.start = (poke_start && lat == 3);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    tick();
    check("resample_done_pulse", 32'(bus.done), 32'd0);
    check("resample_busy_low", 32'(bus.busy), 32'd0);
    exp_mem[a] = ref_loc(w);
  endtask

  initial begin
    logic [M-1:0]  v;
    logic [M-1:0]  old;
    logic [RW-1:0] w;
    logic [LW-1:0] a;
    int lat;
    int d0;
    bit ok;

    vecs[0] = '{24'd0,        15'd0};
    vecs[1] = '{24'd17670,    15'd1};
    vecs[2] = '{24'd16767880, 15'd17668};
    vecs[3] = '{24'd17668,    15'd17668};
    vecs[4] = '{24'd17669,    15'd0};
    vecs[5] = '{24'd100,      15'd100};
    vecs[6] = '{24'd8834623,  15'd123};
    vecs[7] = '{24'd16750212, 15'd0};

    bus.start = 0; bus.rand_in = '0; bus.rand_valid = 0; bus.rd_en = 0;
    bus.rd_addr = '0; bus.resample = 0; bus.resample_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.rand_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_location", 32'(bus.location), 32'd0);
    rst = 1'b0;
    tick();

    // Directed fill: mem[i]=i, a rejected THRESH word before entry 10, stall before entry 25.
    word_q.delete();
    for (int i = 0; i < WEIGHT; i++) begin
      if (i == 10) begin
        word_q.push_back(RW'(THRESH));
        word_q.push_back(24'd16767880);
      end else begin
        word_q.push_back(RW'(i * 17670));
      end
    end
    fill(26);
    readback_all("fill1");
    read_loc(7'd10, v);
    check("reject_then_max", 32'(v), 32'd17668);
    read_loc(7'd11, v);
    check("reject_ptr_once", 32'(v), 32'd11);

    // Resample entry 5 with word 100, with a start pulse while busy that must be ignored.
    d0 = done_cnt;
    resample_one(7'd5, 24'd100, 1'b0, 1'b1, lat);
    check("resample_latency", lat, 32'd12);
    check("resample_done_once", done_cnt - d0, 32'd1);
    tick();
    check("start_while_busy_ignored", 32'(bus.dbg_state), 32'(ST_IDLE));
    readback_all("resample5");

    // Read-then-hold, then a read that collides with a write to the same entry.
    read_loc(7'd3, v);
    check("read3", 32'(v), 32'(exp_mem[3]));
    old = v;
    bus.rd_addr = 7'd9;
    tick(); tick(); tick();
    check("read_hold", 32'(bus.location), 32'(old));
    bus.resample      = 1'b1;
    bus.resample_addr = 7'd3;
    tick();
    bus.resample = 1'b0;
    feed(24'd200, ok);
    repeat (10) tick();
    check("collide_in_write", 32'(bus.dbg_state), 32'(ST_WRITE));
    bus.rd_en   = 1'b1;
    bus.rd_addr = 7'd3;
    tick();
    bus.rd_en = 1'b0;
    check("collide_old_data", 32'(bus.location), 32'(old));
    wait_idle();
    exp_mem[3] = 15'd200;
    read_loc(7'd3, v);
    check("collide_new_data", 32'(v), 32'd200);

    // Vector table applied through resample into entries 0..7.
    for (int i = 0; i < 8; i++) begin
      resample_one(LW'(i), vecs[i].word, 1'b0, 1'b0, lat);
      read_loc(LW'(i), v);
      check($sformatf("vec[%0d]", i), 32'(v), 32'(vecs[i].exp));
    end

    // Random resamples, some preceded by a rejected word.
    for (int i = 0; i < 12; i++) begin
      a = LW'($urandom_range(0, WEIGHT - 1));
      w = RW'($urandom_range(0, THRESH - 1));
      resample_one(a, w, ($urandom_range(0, 2) == 0), 1'b0, lat);
      check("rand_resample_latency", lat, 32'd12);
    end
    for (int i = 0; i < 20; i++) begin
      a = LW'($urandom_range(0, WEIGHT - 1));
      read_loc(a, v);
      check("rand_read", 32'(v), 32'(exp_mem[a]));
    end

    // Random full fill with occasional rejects.
    word_q.delete();
    for (int n = 0; n < WEIGHT; ) begin
      if ($urandom_range(0, 7) == 0) w = RW'($urandom_range(THRESH, 32'hFFFFFF));
      else                           w = RW'($urandom_range(0, 32'hFFFFFF));
      word_q.push_back(w);
      if (accepted(w)) n++;
    end
    fill(-1);
    readback_all("rand_fill");

    // Reset during REDUCE aborts, then a new fill starts again from entry 0.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    feed(24'd5, ok);
    feed(24'd6, ok);
    tick(); tick();
    check("pre_rst_reduce", 32'(bus.dbg_state), 32'(ST_REDUCE));
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("midrst_ready", 32'(bus.rand_ready), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();
    word_q.delete();
    for (int i = 0; i < WEIGHT; i++) word_q.push_back(RW'((WEIGHT - 1 - i) + 7 * N));
    fill(-1);
    read_loc(7'd0, v);
    check("refill_entry0", 32'(v), 32'(WEIGHT - 1));
    readback_all("refill");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
